// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - multi-issue instruction buffer between fetch and decode
//
// Circular buffer of {pc, instruction} entries. Fetch delivers bundles of up to
// ISSUE words; decode sees up to ISSUE oldest words and pops 0..ISSUE per cycle.
// An all-zero instruction terminates the stream and closes enqueue (halted).
//
// Optional feature macro: INST_QUEUE_BYPASS_EN
//   defined   - a bundle enqueued into an empty queue is visible on the outputs
//               in the same cycle and may be consumed before it is stored.
//   undefined - outputs are reads of registered state only (1-cycle latency).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               drop all entries and reopen enqueue
//   in_valid/in_cnt     fetch bundle present / number of valid slots
//   in_pc/in_data       pc of slot 0 / packed slot words (slot i at [i*DW +: DW])
//   in_ready            room for a full bundle and not halted
//   out_cnt/out_pc/out_data  oldest entries presented to decode, slot 0 oldest
//   deq_cnt             words decode consumes this cycle
//   count               occupancy
//   halted              zero word accepted; enqueue closed until flush/rst

`ifndef MULTIPLE_ISSUE
`define MULTIPLE_ISSUE 4
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module inst_queue #(
  parameter int ISSUE = `MULTIPLE_ISSUE,
  parameter int DEPTH = 8,
  parameter int AW    = `BYTE_SIZE,
  parameter int DW    = `WORD_SIZE,
  parameter int CW    = $clog2(ISSUE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [CW-1:0]                in_cnt,
  input  logic [AW-1:0]                in_pc,
  input  logic [ISSUE*DW-1:0]          in_data,
  output logic                         in_ready,
  output logic [CW-1:0]                out_cnt,
  output logic [ISSUE*AW-1:0]          out_pc,
  output logic [ISSUE*DW-1:0]          out_data,
  input  logic [CW-1:0]                deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  int   in_n;      // in_cnt clamped to ISSUE
  int   wr_n;      // words of the bundle that get written (stops before a zero word)
  int   wr_eff;    // wr_n when enqueue fires, else 0
  int   out_n;     // words presented to decode
  int   rm_n;      // words removed this cycle
  logic zero_hit;
  logic enq;
  logic byp;

  // Readiness depends only on registered state so fetch never sees a loop
  // through deq_cnt.
  assign in_ready = !halted && ((DEPTH - int'(count)) >= ISSUE);
  assign enq      = in_valid && in_ready && !flush;

  always_comb begin
    in_n     = (int'(in_cnt) > ISSUE) ? ISSUE : int'(in_cnt);
    wr_n     = in_n;
    zero_hit = 1'b0;
    for (int k = 0; k < ISSUE; k++) begin
      if (k < in_n && !zero_hit && in_data[k*DW +: DW] == '0) begin
        zero_hit = 1'b1;
        wr_n     = k;
      end
    end
    wr_eff = enq ? wr_n : 0;
  end

  always_comb begin
`ifdef INST_QUEUE_BYPASS_EN
    byp = enq && (count == '0);
`else
    byp = 1'b0;
`endif
    out_pc   = '0;
    out_data = '0;
    if (byp) out_n = wr_n;
    else     out_n = (int'(count) > ISSUE) ? ISSUE : int'(count);
    for (int j = 0; j < ISSUE; j++) begin
      if (j < out_n) begin
        if (byp) begin
          out_pc[j*AW +: AW]   = in_pc + AW'(DW * j);
          out_data[j*DW +: DW] = in_data[j*DW +: DW];
        end else begin
          out_pc[j*AW +: AW]   = mem_pc[head + PW'(j)];
          out_data[j*DW +: DW] = mem_data[head + PW'(j)];
        end
      end
    end
    out_cnt = CW'(out_n);
    if (flush) rm_n = 0;
    else       rm_n = (int'(deq_cnt) > out_n) ? out_n : int'(deq_cnt);
  end

  // Entry storage carries no reset; validity is tracked by head/tail/count.
  // With bypass, words consumed in the same cycle are written but head skips
  // past them, so they never become part of the queue.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      for (int i = 0; i < ISSUE; i++) begin
        if (i < wr_n) begin
          mem_pc[tail + PW'(i)]   <= in_pc + AW'(DW * i);
          mem_data[tail + PW'(i)] <= in_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      tail  <= tail + PW'(wr_eff);
      head  <= head + PW'(rm_n);
      count <= NW'(int'(count) + wr_eff - rm_n);
      if (enq && zero_hit) halted <= 1'b1;
    end
  end

endmodule
